// File: rtl/s_pkg.sv
// Shared types and width helpers for the s_accum index-stream accumulator.
package s_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  function automatic int enc_w(input int w);
    return $clog2(w);
  endfunction

  // One extra bit so the count can reach w itself.
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/s_onehot_dec.sv
// Encoded index to one-hot vector decode with an in-range flag; indices >= W
// decode to all zeros instead of wrapping.
module s_onehot_dec
  import s_pkg::*;
#(
  parameter int W = 32,
  localparam int ENC_W = enc_w(W)
) (
  input  logic [ENC_W-1:0] pos,
  output logic [W-1:0]     onehot,
  output logic             in_range
);

  // Range check and plain bitwise decode
  always_comb begin
    in_range = (32'(pos) < 32'(W));
    onehot   = {W{1'b0}};
    for (int i = 0; i < W; i++) begin
      onehot[i] = (pos == ENC_W'(i));
    end
  end

endmodule

// File: rtl/s_accum.sv
// Rebuilds a W-bit vector from a stream of encoded indices and emits it with
// its popcount and error flags. Optional macro: S_ACCUM_BYPASS_EN (no bubble).
module s_accum
  import s_pkg::*;
#(
  parameter int W = 32,
  localparam int ENC_W = enc_w(W),
  localparam int CNT_W = cnt_w(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [ENC_W-1:0] in_pos,
  input  logic             in_last,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [W-1:0]     out_y,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_dup,
  output logic             out_oor,
  input  logic             out_rdy
);

  state_t           state_r, state_s;
  logic [W-1:0]     acc_r, acc_s, base_acc_s, onehot_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, base_cnt_s;
  logic             dup_r, dup_s, oor_r, oor_s;
  logic             in_range_s, beat_s, hs_s;

  s_onehot_dec #(.W(W)) u_dec (
    .pos      (in_pos),
    .onehot   (onehot_s),
    .in_range (in_range_s)
  );

  assign out_vld = (state_r == EMIT);
`ifdef S_ACCUM_BYPASS_EN
  assign in_rdy  = (state_r == ACCUM) | out_rdy;
`else
  assign in_rdy  = (state_r == ACCUM);
`endif

  assign out_y   = acc_r;
  assign out_cnt = cnt_r;
  assign out_dup = dup_r;
  assign out_oor = oor_r;

  // Next-state and accumulator update; a handshake clears before a same-cycle beat lands
  always_comb begin
    state_s    = state_r;
    beat_s     = in_vld & in_rdy;
    hs_s       = out_vld & out_rdy;
    base_acc_s = hs_s ? {W{1'b0}} : acc_r;
    base_cnt_s = hs_s ? {CNT_W{1'b0}} : cnt_r;
    acc_s      = base_acc_s;
    cnt_s      = base_cnt_s;
    dup_s      = hs_s ? 1'b0 : dup_r;
    oor_s      = hs_s ? 1'b0 : oor_r;

    if (beat_s) begin
      if (!in_range_s) begin
        oor_s = 1'b1;
      end else if ((base_acc_s & onehot_s) != {W{1'b0}}) begin
        dup_s = 1'b1;
      end else begin
        acc_s = base_acc_s | onehot_s;
        cnt_s = base_cnt_s + CNT_W'(1);
      end
    end else begin
      acc_s = base_acc_s;
    end

    case (state_r)
      ACCUM: begin
        if (beat_s && in_last) begin
          state_s = EMIT;
        end else begin
          state_s = ACCUM;
        end
      end
      EMIT: begin
        if (hs_s) begin
          state_s = (beat_s && in_last) ? EMIT : ACCUM;
        end else begin
          state_s = EMIT;
        end
      end
      default: state_s = ACCUM;
    endcase
  end

  // State and result registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ACCUM;
      acc_r   <= {W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      dup_r   <= 1'b0;
      oor_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      dup_r   <= dup_s;
      oor_r   <= oor_s;
    end
  end

endmodule
